// File: rtl/uart_tx_fifo.sv
// Show-ahead byte FIFO in front of the UART transmitter: the head entry is always
// visible on o_rd_data, and a pop simply advances to the next entry.
module uart_tx_fifo #(
  parameter int SIZE_DATA   = 8,
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_wr_en,
  input  logic [SIZE_DATA-1:0]      i_wr_data,
  input  logic                      i_rd_en,
  output logic [SIZE_DATA-1:0]      o_rd_data,
  output logic                      o_empty,
  output logic                      o_full,
  output logic                      o_almost_full,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic                      o_overflow,
  output logic                      o_underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LEVEL);

  logic [SIZE_DATA-1:0] mem [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic [SIZE_DATA-1:0] last_data;
  logic                 overflow_q;
  logic                 underflow_q;

  logic empty;
  logic full;
  logic wr_accept;
  logic rd_accept;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // When full, a write is still taken if a pop frees the head slot in the same cycle.
  assign wr_accept = i_wr_en && (!full || i_rd_en);
  assign rd_accept = i_rd_en && !empty;

  always_ff @(posedge i_clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      last_data   <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (wr_accept && !rd_accept) begin
        count <= count + CW'(1);
      end else if (rd_accept && !wr_accept) begin
        count <= count - CW'(1);
      end
      // Tracks the head so the output holds its last value once the FIFO drains.
      if (!empty) begin
        last_data <= mem[rd_ptr];
      end
      overflow_q  <= i_wr_en && full && !i_rd_en;
      underflow_q <= i_rd_en && empty;
    end
  end

  assign o_rd_data     = empty ? last_data : mem[rd_ptr];
  assign o_empty       = empty;
  assign o_full        = full;
  assign o_almost_full = (count >= AFULL_CNT);
  assign o_count       = count;
  assign o_overflow    = overflow_q;
  assign o_underflow   = underflow_q;

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Purpose: synchronous show-ahead byte buffer feeding the UART Transmitter. Its o_rd_data and o_empty drive the Transmitter's i_tx_data and i_fifo_empty; the Transmitter's o_tx_done drives i_rd_en.

Interface
REQ-001 The block SHALL have parameter SIZE_DATA, default 8, giving the data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the number of entries; it SHALL be a power of two and at least 2.
REQ-003 The block SHALL have parameter AFULL_LEVEL, default 12, giving the occupancy at or above which o_almost_full asserts; 1 <= AFULL_LEVEL <= DEPTH.
REQ-004 The block SHALL have input i_clk, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have input i_rst, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have input i_wr_en, 1 bit: write request, one entry per cycle high.
REQ-007 The block SHALL have input i_wr_data, SIZE_DATA bits: the data written when i_wr_en is high.
REQ-008 The block SHALL have input i_rd_en, 1 bit: pop request; the head entry is consumed.
REQ-009 The block SHALL have output o_rd_data, SIZE_DATA bits: the current head entry (show-ahead).
REQ-010 The block SHALL have output o_empty, 1 bit: high when occupancy is 0.
REQ-011 The block SHALL have output o_full, 1 bit: high when occupancy equals DEPTH.
REQ-012 The block SHALL have output o_almost_full, 1 bit: high when occupancy >= AFULL_LEVEL.
REQ-013 The block SHALL have output o_count, clog2(DEPTH)+1 bits: the current occupancy, 0..DEPTH.
REQ-014 The block SHALL have output o_overflow, 1 bit: a one-cycle pulse when a write is dropped.
REQ-015 The block SHALL have output o_underflow, 1 bit: a one-cycle pulse when a pop is ignored.

Function
REQ-016 Storage SHALL be a DEPTH-entry array with write pointer and read pointer, each clog2(DEPTH) bits, wrapping from DEPTH-1 to 0.
REQ-017 Occupancy SHALL be held in a registered counter; o_empty, o_full, o_almost_full and o_count SHALL all be derived from that counter and reflect the state after the last clock edge.
REQ-018 o_rd_data SHALL equal mem[rd_ptr] whenever o_empty is low; when o_empty is high it SHALL hold the last value presented. No read latency is allowed beyond the show-ahead.
REQ-019 A write accepted at edge N SHALL clear o_empty after edge N, and SHALL present the written data on o_rd_data after edge N if the FIFO was empty.
REQ-020 A write is accepted when i_wr_en is high and either o_full is low or i_rd_en is high in the same cycle. An accepted write stores to mem[wr_ptr] and increments wr_ptr.
REQ-021 A pop is accepted when i_rd_en is high and o_empty is low. An accepted pop increments rd_ptr.
REQ-022 Simultaneous accepted write and pop SHALL leave the count unchanged; this includes the full case, where the slot freed by the pop is written in the same cycle.
REQ-023 i_wr_en with o_full high and i_rd_en low: data SHALL be dropped, the pointers and count left unchanged, and o_overflow pulsed high for the following cycle.
REQ-024 i_rd_en with o_empty high: the pop SHALL be ignored and o_underflow pulsed. A simultaneous write SHALL still be accepted, giving count 1.
REQ-025 o_overflow and o_underflow SHALL be registered, high for exactly one cycle per offending request, and never sticky.
REQ-026 The count SHALL never exceed DEPTH nor wrap below 0.

Reset
REQ-027 While i_rst is high at a clock edge, the block SHALL set wr_ptr, rd_ptr and count to 0; o_empty to 1; o_full, o_almost_full, o_overflow and o_underflow to 0; and o_rd_data to 0. Array contents need not be cleared.
REQ-028 Reset SHALL take priority over any i_wr_en or i_rd_en in the same cycle. Reset asserted mid-operation SHALL discard all stored entries.

Verification
REQ-029 Reset, then write 8'h29 for one cycle -> next cycle o_empty=0, o_rd_data=8'h29, o_count=1; pulse i_rd_en -> o_empty=1, o_count=0.
REQ-030 Write 16 bytes 8'h00..8'h0F (DEPTH=16) -> o_almost_full rises when o_count=12, o_full=1 at count 16; a 17th write -> o_overflow one-cycle pulse, count stays 16; popping 16 times returns 8'h00..8'h0F in order.
REQ-031 With the FIFO full, i_wr_en=1 with data 8'hAA and i_rd_en=1 in the same cycle -> o_full stays 1, head advances to 8'h01, and 8'hAA is eventually read last.
REQ-032 With the FIFO empty, i_rd_en=1 with i_wr_en=1 and data 8'h55 -> o_underflow pulses, count=1, o_rd_data=8'h55.
REQ-033 Write 20 and pop 20 in interleaved fashion to force pointer wrap -> data order preserved, no flag pulses.
REQ-034 Load 5 entries, assert i_rst for one cycle alongside i_wr_en=1 -> o_count=0, o_empty=1, all flags 0. Integrated with Transmitter and baud_generator (325, 50 MHz), the serial line reproduces every queued byte.
